// File: rtl/dp_sweep_ctrl.sv
// Sequencer for the byte shift datapath: seeds the register, then issues paced
// shift steps as a one-shot LSB-ward sweep or a continuous LSB/MSB bounce.
module dp_sweep_ctrl #(
   parameter int TICK_DIV = 4,
   parameter int STEPS    = 7
) (
   input  logic       clk_in,
   input  logic       clr_n,
   input  logic       start,
   input  logic       stop,
   input  logic       mode,
   output logic       sel1,
   output logic       sel2,
   output logic [1:0] func,
   output logic       load,
   output logic       clr,
   output logic       busy,
   output logic       done,
   output logic [7:0] sweep_cnt
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [SW-1:0] STEP_MAX  = SW'(STEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SWEEP_R,
      S_SWEEP_L,
      S_FINISH
   } state_e;

   state_e          state_q, state_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [SW-1:0]   step_q, step_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            mode_q, mode_d;
   logic            in_sweep;
   logic            tick;

   assign in_sweep = (state_q == S_SWEEP_R) || (state_q == S_SWEEP_L);
   assign tick     = in_sweep && (presc_q == PRESC_MAX);

   // NOTE: non-blocking assignments here so every register samples the pre-edge values.
   always_ff @(posedge clk_in or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= S_IDLE;
         presc_q <= '0;
         step_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         step_q  <= step_d;
         cnt_q   <= cnt_d;
         mode_q  <= mode_d;
      end
   end

   // NOTE: every _d takes its held value first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      step_d  = step_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      unique case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               state_d = S_INIT;
               mode_d  = mode;
               cnt_d   = '0;
            end
         end
         S_INIT: begin
            presc_d = '0;
            step_d  = '0;
            state_d = stop ? S_FINISH : S_SWEEP_R;
         end
         S_SWEEP_R, S_SWEEP_L: begin
            if (stop) begin
               state_d = S_FINISH;
            end else begin
               presc_d = tick ? '0 : presc_q + 1'b1;
               if (tick) begin
                  if (step_q == STEP_MAX) begin
                     step_d = '0;
                     cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                     if (state_q == S_SWEEP_L) state_d = S_SWEEP_R;
                     else                      state_d = mode_q ? S_SWEEP_L : S_FINISH;
                  end else begin
                     step_d = step_q + 1'b1;
                  end
               end
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Outputs decode registered state only, so inputs never reach them combinationally.
   always_comb begin
      sel2 = 1'b0;
      func = 2'b00;
      load = 1'b0;
      clr  = 1'b0;
      busy = 1'b1;
      done = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            clr  = 1'b1;
            busy = 1'b0;
         end
         S_INIT: load = 1'b1;
         S_SWEEP_R: begin
            sel2 = 1'b1;
            func = 2'b01;
            load = tick;
         end
         S_SWEEP_L: begin
            sel2 = 1'b1;
            func = 2'b10;
            load = tick;
         end
         S_FINISH: done = 1'b1;
         default: begin
            clr  = 1'b1;
            busy = 1'b0;
         end
      endcase
   end

   assign sel1      = 1'b0;
   assign sweep_cnt = cnt_q;

endmodule

// File: tb/tb_dp_sweep_ctrl.sv
// Randomized bench for dp_sweep_ctrl: two instances (4/7 and 1/1 timing) checked
// cycle by cycle against an arithmetic schedule model of a run.
module tb_dp_sweep_ctrl;

   localparam int TD0 = 4;
   localparam int ST0 = 7;
   localparam int TD1 = 1;
   localparam int ST1 = 1;

   typedef struct packed {
      logic       sel1;
      logic       sel2;
      logic [1:0] func;
      logic       load;
      logic       clr;
      logic       busy;
      logic       done;
      logic [7:0] cnt;
   } obs_t;

   logic clk_in, clr_n;
   logic start_a, stop_a, mode_a, start_b, stop_b, mode_b;
   logic sel1_a, sel2_a, load_a, clr_a, busy_a, done_a;
   logic sel1_b, sel2_b, load_b, clr_b, busy_b, done_b;
   logic [1:0] func_a, func_b;
   logic [7:0] cnt_a, cnt_b;

   int n_pass  = 0;
   int n_total = 0;

   dp_sweep_ctrl #(.TICK_DIV(TD0), .STEPS(ST0)) dut_a (
      .clk_in(clk_in), .clr_n(clr_n), .start(start_a), .stop(stop_a), .mode(mode_a),
      .sel1(sel1_a), .sel2(sel2_a), .func(func_a), .load(load_a), .clr(clr_a),
      .busy(busy_a), .done(done_a), .sweep_cnt(cnt_a));

   dp_sweep_ctrl #(.TICK_DIV(TD1), .STEPS(ST1)) dut_b (
      .clk_in(clk_in), .clr_n(clr_n), .start(start_b), .stop(stop_b), .mode(mode_b),
      .sel1(sel1_b), .sel2(sel2_b), .func(func_b), .load(load_b), .clr(clr_b),
      .busy(busy_b), .done(done_b), .sweep_cnt(cnt_b));

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   function automatic logic [7:0] sat8(input int v);
      return (v > 255) ? 8'd255 : 8'(v);
   endfunction

   // Expected outputs in cycle n of a run whose start was sampled at edge 0.
   // a = edge at which stop is sampled (0 = never). Cycle n lies between edges n-1 and n.
   function automatic obs_t model(input int n, input bit md, input int a,
                                  input int td, input int st);
      obs_t e;
      int p, fin, f, s;
      bit ab;
      p   = td * st;
      fin = md ? 32'h3fff_ffff : 2 + p;
      ab  = (a >= 1) && (a < fin);
      f   = ab ? a + 1 : fin;
      e   = '0;
      if (n < f) begin
         e.busy = 1'b1;
         if (n == 1) begin
            e.load = 1'b1;
         end else begin
            s      = (n - 2) / p;
            e.sel2 = 1'b1;
            e.func = (s % 2 == 0) ? 2'b01 : 2'b10;
            e.load = ((n - 2) % td) == (td - 1);
            e.cnt  = sat8(s);
         end
      end else begin
         if (ab) s = (a >= 2) ? (a - 2) / p : 0;
         else    s = (f - 2) / p;
         e.cnt = sat8(s);
         if (n == f) begin
            e.busy = 1'b1;
            e.done = 1'b1;
         end else begin
            e.clr = 1'b1;
         end
      end
      return e;
   endfunction

   function automatic obs_t get_obs(input bit which);
      obs_t o;
      if (which) o = '{sel1_b, sel2_b, func_b, load_b, clr_b, busy_b, done_b, cnt_b};
      else       o = '{sel1_a, sel2_a, func_a, load_a, clr_a, busy_a, done_a, cnt_a};
      return o;
   endfunction

   task automatic drive(input bit which, input bit st, input bit md, input bit sp);
      if (which) begin start_b = st; mode_b = md; stop_b = sp; end
      else       begin start_a = st; mode_a = md; stop_a = sp; end
   endtask

   task automatic cmp(input string name, input int cyc, input obs_t o, input obs_t e);
      n_total++;
      if (o !== e)
         $display("FAIL %s cycle %0d: got sel1=%b sel2=%b func=%b load=%b clr=%b busy=%b done=%b cnt=%0d, want sel1=%b sel2=%b func=%b load=%b clr=%b busy=%b done=%b cnt=%0d",
                  name, cyc, o.sel1, o.sel2, o.func, o.load, o.clr, o.busy, o.done, o.cnt,
                  e.sel1, e.sel2, e.func, e.load, e.clr, e.busy, e.done, e.cnt);
      else
         n_pass++;
   endtask

   // One complete run: start sampled at edge 0, checked until two cycles into IDLE.
   task automatic run(input bit which, input bit md, input int a, input bit hold,
                      input string name);
      int td, st, fin, f;
      td  = which ? TD1 : TD0;
      st  = which ? ST1 : ST0;
      fin = md ? 32'h3fff_ffff : 2 + td * st;
      f   = ((a >= 1) && (a < fin)) ? a + 1 : fin;
      @(negedge clk_in);
      drive(which, 1'b1, md, 1'b0);
      for (int n = 1; n <= f + 2; n++) begin
         @(negedge clk_in);
         cmp(name, n, get_obs(which), model(n, md, a, td, st));
         drive(which, hold && (n < f), 1'($urandom_range(0, 1)), n == a);
      end
   endtask

   task automatic test_reset();
      obs_t idle;
      idle     = '0;
      idle.clr = 1'b1;
      cmp("reset_a", 0, get_obs(1'b0), idle);
      cmp("reset_b", 0, get_obs(1'b1), idle);
   endtask

   task automatic test_oneshot();
      run(1'b0, 1'b0, 0, 1'b0, "oneshot");
   endtask

   task automatic test_bounce();
      run(1'b0, 1'b1, 80, 1'b0, "bounce");
   endtask

   task automatic test_abort();
      run(1'b0, 1'b0, 12, 1'b0, "abort");
      run(1'b0, 1'b0, 29, 1'b0, "abort_last_step");
      run(1'b0, 1'b0, 1, 1'b0, "abort_init");
   endtask

   task automatic test_start_stop_idle();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_in);
         drive(1'b0, 1'b1, 1'b0, 1'b1);
         @(negedge clk_in);
         n_total++;
         if ({busy_a, clr_a, load_a, done_a} !== 4'b0100)
            $display("FAIL start_stop_idle: got busy/clr/load/done=%b want 0100",
                     {busy_a, clr_a, load_a, done_a});
         else
            n_pass++;
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      run(1'b0, 1'b0, 0, 1'b1, "held_start");
      run(1'b0, 1'b0, 0, 1'b0, "back_to_back");
   endtask

   task automatic test_min_cfg();
      run(1'b1, 1'b0, 0, 1'b0, "min_oneshot");
      run(1'b1, 1'b1, 9, 1'b0, "min_bounce");
   endtask

   task automatic test_saturate();
      run(1'b1, 1'b1, 300, 1'b0, "saturate");
   endtask

   task automatic test_random();
      for (int i = 0; i < 20; i++) begin
         bit which, md, hold;
         int a, fin;
         which = 1'($urandom_range(0, 1));
         md    = 1'($urandom_range(0, 1));
         hold  = 1'($urandom_range(0, 1));
         fin   = which ? 2 + TD1 * ST1 : 2 + TD0 * ST0;
         if (md) a = $urandom_range(1, which ? 40 : 120);
         else    a = $urandom_range(0, fin + 2);
         run(which, md, a, hold, $sformatf("rand%0d", i));
      end
   endtask

   task automatic test_async_reset();
      obs_t idle;
      idle     = '0;
      idle.clr = 1'b1;
      @(negedge clk_in);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      for (int n = 1; n <= 61; n++) begin
         @(negedge clk_in);
         cmp("pre_reset", n, get_obs(1'b0), model(n, 1'b1, 0, TD0, ST0));
         drive(1'b0, 1'b0, 1'b1, 1'b0);
      end
      #2 clr_n = 1'b0;
      #1 cmp("async_reset", 61, get_obs(1'b0), idle);
      @(negedge clk_in);
      cmp("held_reset", 62, get_obs(1'b0), idle);
      clr_n = 1'b1;
      @(negedge clk_in);
      cmp("after_reset", 63, get_obs(1'b0), idle);
   endtask

   initial begin
      clr_n = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      #1 test_reset();
      @(negedge clk_in);
      @(negedge clk_in);
      clr_n = 1'b1;
      test_oneshot();
      test_bounce();
      test_abort();
      test_start_stop_idle();
      test_back_to_back();
      test_min_cfg();
      test_saturate();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
